// File: rtl/audio_pkg.sv
// Shared definitions for the audio tone generator: envelope states, note table,
// and the clock-dependent half-period table builder.
package audio_pkg;

  localparam int unsigned VOL_W      = 5;
  localparam int unsigned SEL_W      = 4;
  localparam int unsigned NUM_NOTES  = 16;
  localparam int unsigned PWM_PERIOD = 31;

  typedef enum logic [1:0] {
    ENV_IDLE    = 2'd0,
    ENV_ATTACK  = 2'd1,
    ENV_SUSTAIN = 2'd2,
    ENV_RELEASE = 2'd3
  } env_state_t;

  // C4..D#5 in equal-tempered semitones, milli-Hz
  localparam int unsigned NOTE_MHZ [NUM_NOTES] = '{
    261626, 277183, 293665, 311127, 329628, 349228, 369994, 391995,
    415305, 440000, 466164, 493883, 523251, 554365, 587330, 622254
  };

  // Half-period in clock cycles per note: round(clk_hz / (2 * f))
  function automatic logic [NUM_NOTES-1:0][31:0] half_table(input int unsigned clk_hz);
    logic [63:0] num;
    logic [63:0] den;
    half_table = '0;
    for (int i = 0; i < int'(NUM_NOTES); i++) begin
      num = 64'(clk_hz) * 64'd1000;
      den = 64'(NOTE_MHZ[i]) * 64'd2;
      half_table[i] = 32'((num + (den >> 1)) / den);
    end
  endfunction

endpackage

// File: rtl/audio_env.sv
// Linear attack/release envelope: free-running tick prescaler plus envelope FSM.
module audio_env
  import audio_pkg::*;
#(
  parameter int unsigned ENV_DIV = 65536
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VOL_W-1:0] vol,
  input  logic             en,
  output logic [VOL_W-1:0] level,
  output env_state_t       state
);

  localparam int unsigned PRE_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;

  logic [PRE_W-1:0] pre;
  logic             tick_c;

  assign tick_c = (pre == PRE_W'(ENV_DIV - 1));

  // Prescaler is only cleared by reset so tick spacing never depends on note activity
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       pre <= '0;
    else if (tick_c) pre <= '0;
    else             pre <= pre + PRE_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ENV_IDLE;
      level <= '0;
    end else begin
      case (state)
        ENV_IDLE: begin
          level <= '0;
          if (en) state <= ENV_ATTACK;
        end
        ENV_ATTACK: begin
          if (!en) begin
            state <= ENV_RELEASE;
          end else if (level >= vol) begin
            state <= ENV_SUSTAIN;
            level <= vol;
          end else if (tick_c && (level != '1)) begin
            level <= level + VOL_W'(1);
          end
        end
        ENV_SUSTAIN: begin
          level <= vol;
          if (!en) state <= ENV_RELEASE;
        end
        ENV_RELEASE: begin
          // Re-gating resumes the attack from the current level
          if (en) begin
            state <= ENV_ATTACK;
          end else if (tick_c) begin
            if (level <= VOL_W'(1)) begin
              level <= '0;
              state <= ENV_IDLE;
            end else begin
              level <= level - VOL_W'(1);
            end
          end
        end
        default: state <= ENV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/audio_tone_gen.sv
// Square-wave tone generator with PWM volume and envelope shaping, driving the
// board audio pin from the processor's audio control outputs.
module audio_tone_gen
  import audio_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 25000000,
  parameter int unsigned ENV_DIV = 65536,
  parameter int unsigned DIV_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VOL_W-1:0] audioVol,
  input  logic [SEL_W-1:0] audioSel,
  input  logic             audioEn,
  output logic             audio_out,
  output logic             note_active,
  output logic [1:0]       env_state,
  output logic [VOL_W-1:0] env_level
);

  localparam logic [NUM_NOTES-1:0][31:0] HALF_TBL = half_table(CLK_HZ);

  logic [VOL_W-1:0] vol_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;
  logic             en_q;
  env_state_t       state;
  logic [VOL_W-1:0] level;
  logic [DIV_W-1:0] tone_cnt;
  logic [DIV_W-1:0] half_c;
  logic             phase;
  logic [VOL_W-1:0] pwm_cnt;
  logic             restart_c;
  logic             pwm_on_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vol_q <= '0;
      sel_q <= '0;
      sel_d <= '0;
      en_q  <= 1'b0;
    end else begin
      vol_q <= audioVol;
      sel_q <= audioSel;
      sel_d <= sel_q;
      en_q  <= audioEn;
    end
  end

  audio_env #(.ENV_DIV(ENV_DIV)) u_env (
    .clk   (clk),
    .reset (reset),
    .vol   (vol_q),
    .en    (en_q),
    .level (level),
    .state (state)
  );

  assign half_c    = DIV_W'(HALF_TBL[sel_q]);
  // Restart the waveform cleanly on a note change or a fresh note start
  assign restart_c = (sel_q != sel_d) || ((state == ENV_IDLE) && en_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tone_cnt <= '0;
      phase    <= 1'b0;
    end else if (restart_c) begin
      tone_cnt <= '0;
      phase    <= 1'b0;
    end else if (tone_cnt == half_c - DIV_W'(1)) begin
      tone_cnt <= '0;
      phase    <= ~phase;
    end else begin
      tone_cnt <= tone_cnt + DIV_W'(1);
    end
  end

  assign pwm_on_c = (pwm_cnt < level);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt   <= '0;
      audio_out <= 1'b0;
    end else begin
      pwm_cnt   <= (pwm_cnt == VOL_W'(PWM_PERIOD - 1)) ? '0 : pwm_cnt + VOL_W'(1);
      audio_out <= phase & pwm_on_c;
    end
  end

  assign env_state   = state;
  assign note_active = (state != ENV_IDLE);
  assign env_level   = level;

endmodule

// File: tb/tb_audio_tone_gen.sv
// Self-checking bench for audio_tone_gen: directed scenarios plus randomized gating,
// compared each cycle against a closed-form reference model.
module tb_audio_tone_gen;

  localparam int ENV_DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] audioVol;
  logic [3:0] audioSel;
  logic       audioEn;
  logic       audio_out;
  logic       note_active;
  logic [1:0] env_state;
  logic [4:0] env_level;

  int tests = 0;
  int fails = 0;

  // Reference model state (values after the most recent edge)
  int n, t0, seg_half;
  int m_vol, m_sel, m_sel_prev, m_en, m_state, m_level, m_audio;

  audio_tone_gen #(.CLK_HZ(25000000), .ENV_DIV(ENV_DIV), .DIV_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .audioVol    (audioVol),
    .audioSel    (audioSel),
    .audioEn     (audioEn),
    .audio_out   (audio_out),
    .note_active (note_active),
    .env_state   (env_state),
    .env_level   (env_level)
  );

  always #5 clk = ~clk;

  function automatic int half_of(input int sel);
    case (sel)
      0:       return 47778;
      9:       return 28409;
      12:      return 23889;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    n = 0; t0 = 0; seg_half = half_of(0);
    m_vol = 0; m_sel = 0; m_sel_prev = 0; m_en = 0;
    m_state = 0; m_level = 0; m_audio = 0;
  endtask

  // Phase and PWM positions are closed-form functions of the edge index
  task automatic model_edge();
    int tick, phase_prev, pwm_prev, restart, ns, nl;
    n++;
    tick       = (n % ENV_DIV == 0) ? 1 : 0;
    phase_prev = ((n - 1 - t0) / seg_half) % 2;
    pwm_prev   = (n - 1) % 31;
    restart    = ((m_sel != m_sel_prev) || (m_state == 0 && m_en == 1)) ? 1 : 0;
    ns = m_state;
    nl = m_level;
    case (m_state)
      0: begin nl = 0; if (m_en == 1) ns = 1; end
      1: begin
        if (m_en == 0) ns = 3;
        else if (m_level >= m_vol) begin ns = 2; nl = m_vol; end
        else if (tick == 1) nl = (m_level < 31) ? m_level + 1 : 31;
      end
      2: begin nl = m_vol; if (m_en == 0) ns = 3; end
      default: begin
        if (m_en == 1) ns = 1;
        else if (tick == 1) begin
          nl = (m_level > 0) ? m_level - 1 : 0;
          if (nl == 0) ns = 0;
        end
      end
    endcase
    if (restart == 1) begin
      t0 = n;
      seg_half = half_of(int'(audioSel));
    end
    m_audio    = (phase_prev == 1 && pwm_prev < m_level) ? 1 : 0;
    m_sel_prev = m_sel;
    m_sel      = int'(audioSel);
    m_vol      = int'(audioVol);
    m_en       = int'(audioEn);
    m_state    = ns;
    m_level    = nl;
  endtask

  task automatic check_outputs(input string tag);
    logic [8:0] obs, exp;
    obs = {audio_out, note_active, env_state, env_level};
    exp = {1'(m_audio), (m_state != 0), 2'(m_state), 5'(m_level)};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, n, obs, exp);
    end
  endtask

  task automatic step(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_outputs(tag);
    end
  endtask

  function automatic logic [3:0] pick_sel();
    case ($urandom_range(2))
      0:       return 4'd0;
      1:       return 4'd9;
      default: return 4'd12;
    endcase
  endfunction

  initial begin
    reset = 1'b1; audioVol = 5'd5; audioSel = 4'd9; audioEn = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("in_reset");
    @(negedge clk) reset = 1'b0;

    step(1, "start");
    check_val("idle_edge1", 32'(env_state), 32'd0);
    step(1, "start");
    check_val("attack_edge2", 32'(env_state), 32'd1);
    step(20, "attack");
    check_val("sustain_state", 32'(env_state), 32'd2);
    check_val("sustain_level", 32'(env_level), 32'd5);

    // Full volume: pin follows the tone phase; first toggle 28409 edges after start
    audioVol = 5'd31;
    step(28389, "tone9");
    check_val("tone9_low", 32'(audio_out), 32'd0);
    step(1, "tone9");
    check_val("tone9_high", 32'(audio_out), 32'd1);

    audioSel = 4'd12;
    step(3, "sel_change");
    check_val("sel_restart_low", 32'(audio_out), 32'd0);
    check_val("sel_level_kept", 32'(env_level), 32'd31);
    step(23888, "tone12");
    check_val("tone12_low", 32'(audio_out), 32'd0);
    step(1, "tone12");
    check_val("tone12_high", 32'(audio_out), 32'd1);

    audioEn = 1'b0;
    step(150, "release");
    check_val("release_idle", 32'(env_state), 32'd0);
    check_val("release_inactive", 32'(note_active), 32'd0);
    check_val("release_silent", 32'(audio_out), 32'd0);

    audioVol = 5'd5; audioEn = 1'b1;
    step(40, "reattack");
    audioEn = 1'b0;
    for (int i = 0; i < 40 && m_level != 3; i++) step(1, "to_level3");
    check_val("rel_level3", 32'(env_level), 32'd3);
    audioEn = 1'b1;
    step(2, "resume");
    check_val("resume_attack", 32'(env_state), 32'd1);
    check_val("resume_nonzero", 32'(env_level >= 5'd2), 32'd1);
    step(30, "resume");

    audioEn = 1'b0;
    step(40, "to_idle");
    audioVol = 5'd0; audioEn = 1'b1;
    step(2, "vol0");
    check_val("vol0_attack", 32'(env_state), 32'd1);
    step(1, "vol0");
    check_val("vol0_sustain", 32'(env_state), 32'd2);
    check_val("vol0_level", 32'(env_level), 32'd0);
    step(100, "vol0");
    check_val("vol0_silent", 32'(audio_out), 32'd0);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0)  audioEn  = ~audioEn;
      if ($urandom_range(15) == 0) audioVol = 5'($urandom_range(31));
      if ($urandom_range(63) == 0) audioSel = pick_sel();
      step(1, "random");
    end

    // Asynchronous reset in the middle of a note
    audioEn = 1'b1; audioVol = 5'd31;
    step(60, "pre_reset");
    #2 reset = 1'b1;
    #1;
    check_val("async_audio", 32'(audio_out), 32'd0);
    check_val("async_state", 32'(env_state), 32'd0);
    model_reset();
    check_outputs("async_reset");
    @(negedge clk) reset = 1'b0;
    step(30, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
